ysyx_25020047_lsu_bus: RTL and testbench

Multi-cycle load/store unit between EXU and WBU. Accepts one memory op at a time over a valid/ready handshake, issues a single request on a decoupled memory bus with byte strobes, and aligns and extends the load data. Reports misaligned accesses, bus errors and response timeouts as RISC-V exception codes. Generalises the former combinational LSU in data width, adds a bus handshake, and replaces one-hot type decode with funct3 encoding.

---
 rtl/ysyx_25020047_lsu_bus.sv | 234 +++++++++++++++++++++++
 tb/tb_ysyx_25020047_lsu_bus.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_lsu_bus.sv
// ysyx_25020047_lsu_bus
// Multi-cycle load/store unit sitting between EXU and WBU. Takes one memory
// op at a time, issues a single request on a decoupled memory bus with byte
// strobes, then aligns and sign/zero-extends the returned load data.
// Misaligned/illegal accesses, bus errors and response timeouts come back as
// RISC-V exception causes (4/5/6/7).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       EXU op handshake
//   in_kind                 0 none, 1 load, 2 store, 3 reserved (as none)
//   in_funct3               000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
//   in_addr, in_wdata       byte address, LSB-aligned store data
//   mem_req_*               request: we, word-aligned addr, lane-shifted wdata, wstrb
//   mem_resp_*              response: rdata (full bus word), err, ready
//   out_valid/out_ready     WBU handshake
//   out_data/out_exc/out_cause  result, exception flag, cause
//   dbg_state               current FSM state (IDLE=0, REQ=1, RESP=2, DONE=3)
//
// Handshakes: every channel transfers on a rising edge where valid and ready
// are both high. A source keeps valid high and its payload stable until that
// transfer happens; valid never depends combinationally on ready. All outputs
// here are registered.
module ysyx_25020047_lsu_bus #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_kind,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [XLEN-1:0]       in_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [XLEN-1:0]       mem_req_wdata,
  output logic [XLEN/8-1:0]     mem_req_wstrb,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [XLEN-1:0]       mem_resp_rdata,
  input  logic                  mem_resp_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_exc,
  output logic [3:0]            out_cause,
  output logic [1:0]            dbg_state
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  logic               store_q;
  logic [2:0]         f3_q;
  logic [OFF_W-1:0]   off_q;
  logic [CNT_W-1:0]   cnt;

  assign dbg_state = state;

  // Accept-time decode of the incoming op.
  logic              is_load;
  logic              is_store;
  logic              illegal;
  logic              misaligned;
  logic [OFF_W-1:0]  in_off;
  logic [NB-1:0]     strb;
  logic [XLEN-1:0]   wdata_lane;

  always_comb begin
    is_load    = (in_kind == 2'd1);
    is_store   = (in_kind == 2'd2);
    in_off     = in_addr[OFF_W-1:0];
    // d and wu do not exist on a 32-bit bus; 111 never exists.
    illegal    = (in_funct3 == 3'b111) ||
                 ((XLEN == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
    misaligned = 1'b0;
    strb       = '1;
    case (in_funct3[1:0])
      2'd0: strb = NB'(1) << in_off;
      2'd1: begin
        misaligned = in_addr[0];
        strb       = NB'(3) << in_off;
      end
      2'd2: begin
        misaligned = |in_addr[1:0];
        strb       = NB'(4'hF) << in_off;
      end
      default: begin
        misaligned = |in_addr[2:0];
        strb       = '1;
      end
    endcase
    wdata_lane = in_wdata << {in_off, 3'b000};
  end

  // Load data: pick the addressed lane, then extend. Done at 64 bits so the
  // same expressions serve both bus widths.
  logic [63:0]     lane;
  logic [63:0]     ext;
  logic [XLEN-1:0] load_data;

  always_comb begin
    lane = 64'(mem_resp_rdata >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ext = {{56{lane[7]}},  lane[7:0]};
      3'b001:  ext = {{48{lane[15]}}, lane[15:0]};
      3'b010:  ext = {{32{lane[31]}}, lane[31:0]};
      3'b100:  ext = {56'd0, lane[7:0]};
      3'b101:  ext = {48'd0, lane[15:0]};
      3'b110:  ext = {32'd0, lane[31:0]};
      default: ext = lane;
    endcase
    load_data = ext[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      in_ready       <= 1'b1;
      store_q        <= 1'b0;
      f3_q           <= 3'd0;
      off_q          <= '0;
      cnt            <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      mem_req_wstrb  <= '0;
      mem_resp_ready <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_exc        <= 1'b0;
      out_cause      <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready      <= 1'b0;
            store_q       <= is_store;
            f3_q          <= in_funct3;
            off_q         <= in_off;
            mem_req_we    <= is_store;
            mem_req_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_req_wdata <= wdata_lane;
            mem_req_wstrb <= is_store ? strb : '0;
            out_data      <= '0;
            if (!is_load && !is_store) begin
              out_exc   <= 1'b0;
              out_cause <= 4'd0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else if (illegal || misaligned) begin
              out_exc   <= 1'b1;
              out_cause <= is_store ? CAUSE_ST_MIS : CAUSE_LD_MIS;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              mem_req_valid <= 1'b1;
              state         <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            cnt            <= '0;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          // A response arriving while cnt == TIMEOUT still wins over the fault.
          if (mem_resp_valid) begin
            mem_resp_ready <= 1'b0;
            out_valid      <= 1'b1;
            state          <= S_DONE;
            if (mem_resp_err) begin
              out_exc   <= 1'b1;
              out_cause <= store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
              out_data  <= '0;
            end else begin
              out_exc   <= 1'b0;
              out_cause <= 4'd0;
              out_data  <= store_q ? '0 : load_data;
            end
          end else if (TIMEOUT != 0) begin
            if (cnt == TO_CNT) begin
              mem_resp_ready <= 1'b0;
              out_valid      <= 1'b1;
              out_exc        <= 1'b1;
              out_cause      <= store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
              out_data       <= '0;
              state          <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_exc   <= 1'b0;
            out_cause <= 4'd0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu_bus.sv
module tb_ysyx_25020047_lsu_bus;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 32-bit instance, short timeout
  logic        in_valid, in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_exc;
  logic [31:0] out_data;
  logic [3:0]  out_cause;
  logic [1:0]  dbg_state;

  // 64-bit instance
  logic        w_in_valid, w_in_ready;
  logic [1:0]  w_in_kind;
  logic [2:0]  w_in_funct3;
  logic [31:0] w_in_addr;
  logic [63:0] w_in_wdata;
  logic        w_mem_req_valid, w_mem_req_ready, w_mem_req_we;
  logic [31:0] w_mem_req_addr;
  logic [63:0] w_mem_req_wdata;
  logic [7:0]  w_mem_req_wstrb;
  logic        w_mem_resp_valid, w_mem_resp_ready, w_mem_resp_err;
  logic [63:0] w_mem_resp_rdata;
  logic        w_out_valid, w_out_ready, w_out_exc;
  logic [63:0] w_out_data;
  logic [3:0]  w_out_cause;
  logic [1:0]  w_dbg_state;

  ysyx_25020047_lsu_bus #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exc(out_exc), .out_cause(out_cause), .dbg_state(dbg_state)
  );

  ysyx_25020047_lsu_bus #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_kind(w_in_kind),
    .in_funct3(w_in_funct3), .in_addr(w_in_addr), .in_wdata(w_in_wdata),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready),
    .mem_req_we(w_mem_req_we), .mem_req_addr(w_mem_req_addr),
    .mem_req_wdata(w_mem_req_wdata), .mem_req_wstrb(w_mem_req_wstrb),
    .mem_resp_valid(w_mem_resp_valid), .mem_resp_ready(w_mem_resp_ready),
    .mem_resp_rdata(w_mem_resp_rdata), .mem_resp_err(w_mem_resp_err),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_exc(w_out_exc), .out_cause(w_out_cause), .dbg_state(w_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] exp_q[$];   // {exc, cause[3:0], data[31:0]}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One op on the 32-bit instance. Inputs change on negedges; outputs are
  // sampled on negedges. n counts cycles after the accept edge.
  task automatic run32(input string tag, input logic [1:0] kind, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit bus, input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                       input int req_wait, input int resp_wait, input bit resp_en,
                       input logic [31:0] rdata, input bit err,
                       input logic [31:0] e_data, input bit e_exc, input logic [3:0] e_cause,
                       input int e_lat, input int out_wait);
    int n;
    int k;
    logic [31:0] e_addr;
    logic [36:0] e;
    e_addr = {addr[31:2], 2'b00};
    exp_q.push_back({e_exc, e_cause, e_data});
    check_eq({tag, ":in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    in_kind   = kind;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    check_eq({tag, ":busy"}, in_ready, 0);
    if (bus) begin
      for (int i = 0; i <= req_wait; i++) begin
        check_eq({tag, ":req_valid"}, mem_req_valid, 1);
        check_eq({tag, ":req_addr"}, mem_req_addr, e_addr);
        check_eq({tag, ":req_wdata"}, mem_req_wdata, e_wdata);
        check_eq({tag, ":req_wstrb"}, mem_req_wstrb, e_wstrb);
        check_eq({tag, ":req_we"}, mem_req_we, kind == 2'd2);
        if (i < req_wait) begin
          @(negedge clk);
          n++;
        end
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      n++;
      check_eq({tag, ":req_dropped"}, mem_req_valid, 0);
      check_eq({tag, ":resp_ready"}, mem_resp_ready, 1);
      for (int i = 0; i < resp_wait; i++) begin
        @(negedge clk);
        n++;
      end
      if (resp_en) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        mem_resp_err   = err;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        n++;
      end
    end else begin
      check_eq({tag, ":no_req"}, mem_req_valid, 0);
    end
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      n++;
      k++;
    end
    check_eq({tag, ":out_valid"}, out_valid, 1);
    check_eq({tag, ":latency"}, n, e_lat);
    if (!bus) check_eq({tag, ":no_bus"}, mem_req_valid, 0);
    e = exp_q.pop_front();
    check_eq({tag, ":data"}, out_data, e[31:0]);
    check_eq({tag, ":exc"}, out_exc, e[36]);
    check_eq({tag, ":cause"}, out_cause, e[35:32]);
    for (int i = 0; i < out_wait; i++) begin
      @(negedge clk);
      check_eq({tag, ":hold_valid"}, out_valid, 1);
      check_eq({tag, ":hold_data"}, out_data, e[31:0]);
      check_eq({tag, ":hold_busy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ":released"}, out_valid, 0);
    check_eq({tag, ":idle_ready"}, in_ready, 1);
  endtask

  // Zero-wait load on the 64-bit instance.
  task automatic run64(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] rdata, input logic [31:0] e_addr,
                       input logic [63:0] e_data);
    w_in_valid  = 1'b1;
    w_in_kind   = 2'd1;
    w_in_funct3 = f3;
    w_in_addr   = addr;
    w_in_wdata  = '0;
    @(posedge clk);
    @(negedge clk);
    w_in_valid = 1'b0;
    check_eq({tag, ":req_valid"}, w_mem_req_valid, 1);
    check_eq({tag, ":req_addr"}, w_mem_req_addr, e_addr);
    check_eq({tag, ":req_wstrb"}, w_mem_req_wstrb, 0);
    w_mem_req_ready = 1'b1;
    @(negedge clk);
    w_mem_req_ready  = 1'b0;
    w_mem_resp_valid = 1'b1;
    w_mem_resp_rdata = rdata;
    @(negedge clk);
    w_mem_resp_valid = 1'b0;
    check_eq({tag, ":out_valid"}, w_out_valid, 1);
    check_eq({tag, ":data"}, w_out_data, e_data);
    check_eq({tag, ":exc"}, w_out_exc, 0);
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
    check_eq({tag, ":idle_ready"}, w_in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_kind = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; mem_resp_err = 0; out_ready = 0;
    w_in_valid = 0; w_in_kind = 0; w_in_funct3 = 0; w_in_addr = 0; w_in_wdata = 0;
    w_mem_req_ready = 0; w_mem_resp_valid = 0; w_mem_resp_rdata = 0; w_mem_resp_err = 0;
    w_out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst:in_ready", in_ready, 1);
    check_eq("rst:req_valid", mem_req_valid, 0);
    check_eq("rst:resp_ready", mem_resp_ready, 0);
    check_eq("rst:out_valid", out_valid, 0);
    check_eq("rst:out_exc", out_exc, 0);
    check_eq("rst:out_cause", out_cause, 0);
    check_eq("rst:out_data", out_data, 0);
    check_eq("rst:wstrb", mem_req_wstrb, 0);
    check_eq("rst:state", dbg_state, 0);
    check_eq("rst64:in_ready", w_in_ready, 1);
    check_eq("rst64:out_valid", w_out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    //     tag      kind  f3     addr          wdata         bus e_wdata       strb  rqw rsw en rdata         err e_data        exc cause lat ow
    run32("lbu",    2'd1, 3'b100, 32'h80000003, 32'h0,        1, 32'h0,        4'h0, 0,  0,  1, 32'hAB123456, 0, 32'h000000AB, 0, 4'd0, 3,  0);
    run32("lb",     2'd1, 3'b000, 32'h80000003, 32'h0,        1, 32'h0,        4'h0, 0,  0,  1, 32'hAB123456, 0, 32'hFFFFFFAB, 0, 4'd0, 3,  0);
    run32("lbu1",   2'd1, 3'b100, 32'h80000001, 32'h0,        1, 32'h0,        4'h0, 0,  0,  1, 32'hAB123456, 0, 32'h00000034, 0, 4'd0, 3,  0);
    run32("lh",     2'd1, 3'b001, 32'h80000002, 32'h0,        1, 32'h0,        4'h0, 0,  0,  1, 32'h80011234, 0, 32'hFFFF8001, 0, 4'd0, 3,  0);
    run32("lhu_bp", 2'd1, 3'b101, 32'h80000002, 32'h0,        1, 32'h0,        4'h0, 0,  0,  1, 32'h80011234, 0, 32'h00008001, 0, 4'd0, 3,  5);
    run32("sh",     2'd2, 3'b001, 32'h80000002, 32'h0000BEEF, 1, 32'hBEEF0000, 4'hC, 0,  0,  1, 32'hDEADBEEF, 0, 32'h0,        0, 4'd0, 3,  0);
    run32("sb",     2'd2, 3'b000, 32'h80000001, 32'h000000A5, 1, 32'h0000A500, 4'h2, 0,  0,  1, 32'h0,        0, 32'h0,        0, 4'd0, 3,  0);
    run32("sw_wait",2'd2, 3'b010, 32'h80000004, 32'h11223344, 1, 32'h11223344, 4'hF, 10, 0,  1, 32'h0,        0, 32'h0,        0, 4'd0, 13, 0);
    run32("lw_err", 2'd1, 3'b010, 32'h80000008, 32'h0,        1, 32'h0,        4'h0, 0,  0,  1, 32'h12345678, 1, 32'h0,        1, 4'd5, 3,  0);
    run32("lw_mis", 2'd1, 3'b010, 32'h80000001, 32'h0,        0, 32'h0,        4'h0, 0,  0,  0, 32'h0,        0, 32'h0,        1, 4'd4, 1,  0);
    run32("sh_mis", 2'd2, 3'b001, 32'h80000003, 32'h0000BEEF, 0, 32'h0,        4'h0, 0,  0,  0, 32'h0,        0, 32'h0,        1, 4'd6, 1,  0);
    run32("none",   2'd0, 3'b010, 32'h80000001, 32'h0,        0, 32'h0,        4'h0, 0,  0,  0, 32'h0,        0, 32'h0,        0, 4'd0, 1,  0);
    run32("rsvd",   2'd3, 3'b000, 32'h80000000, 32'h0,        0, 32'h0,        4'h0, 0,  0,  0, 32'h0,        0, 32'h0,        0, 4'd0, 1,  0);
    run32("ld32",   2'd1, 3'b011, 32'h80000000, 32'h0,        0, 32'h0,        4'h0, 0,  0,  0, 32'h0,        0, 32'h0,        1, 4'd4, 1,  0);
    run32("swu32",  2'd2, 3'b110, 32'h80000000, 32'h0,        0, 32'h0,        4'h0, 0,  0,  0, 32'h0,        0, 32'h0,        1, 4'd6, 1,  0);
    run32("sw_to",  2'd2, 3'b010, 32'h80000004, 32'h55667788, 1, 32'h55667788, 4'hF, 0,  0,  0, 32'h0,        0, 32'h0,        1, 4'd7, 7,  0);
    run32("lw_edge",2'd1, 3'b010, 32'h80000000, 32'h0,        1, 32'h0,        4'h0, 0,  4,  1, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 0, 4'd0, 7,  0);

    // Reset while waiting in RESP aborts the op immediately.
    in_valid = 1'b1; in_kind = 2'd1; in_funct3 = 3'b010; in_addr = 32'h80000010; in_wdata = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check_eq("rstmid:in_resp", mem_resp_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid:resp_ready", mem_resp_ready, 0);
    check_eq("rstmid:in_ready", in_ready, 1);
    check_eq("rstmid:out_valid", out_valid, 0);
    check_eq("rstmid:req_valid", mem_req_valid, 0);
    check_eq("rstmid:state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run32("after_rst", 2'd1, 3'b010, 32'h80000010, 32'h0, 1, 32'h0, 4'h0, 0, 0, 1, 32'h01020304, 0, 32'h01020304, 0, 4'd0, 3, 0);

    run64("ld64",  3'b011, 32'h80000008, 64'h0123456789ABCDEF, 32'h80000008, 64'h0123456789ABCDEF);
    run64("lwu64", 3'b110, 32'h80000004, 64'h8000000011223344, 32'h80000000, 64'h0000000080000000);
    run64("lw64",  3'b010, 32'h80000004, 64'h8000000011223344, 32'h80000000, 64'hFFFFFFFF80000000);
    run64("lb64",  3'b000, 32'h80000007, 64'h8000000011223344, 32'h80000000, 64'hFFFFFFFFFFFFFF80);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
